// File: rtl/fp_div_pkg.sv
// Shared constants and types for the floating-point divider significand path.
package fp_div_pkg;

    localparam int MANT_W = 24;
    localparam int QBITS  = 27;
    localparam int REM_W  = 27;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } divState_t;

    // Exponent adjustments consumed by the underflow check.
    localparam logic [7:0] EXP_ADJ_NONE = 8'd0;
    localparam logic [7:0] EXP_ADJ_M1   = 8'hFF;

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring division step; with corr=1 it performs the final
// remainder correction (add B back when the remainder is negative).
module nr_div_step
    import fp_div_pkg::*;
(
    input  logic [REM_W-1:0]  remIn,
    input  logic [MANT_W-1:0] divisor,
    input  logic              corr,
    output logic [REM_W-1:0]  remOut,
    output logic              qBit
);

    logic [REM_W-1:0] bExt;
    logic [REM_W-1:0] shifted;
    logic             remNeg;

    assign bExt    = {{(REM_W-MANT_W){1'b0}}, divisor};
    assign shifted = {remIn[REM_W-2:0], 1'b0};
    assign remNeg  = remIn[REM_W-1];

    always_comb begin
        remOut = remIn;
        if (corr) begin
            remOut = remNeg ? (remIn + bExt) : remIn;
        end else begin
            remOut = remNeg ? (shifted + bExt) : (shifted - bExt);
        end
        qBit = ~remOut[REM_W-1];
    end

endmodule

// File: rtl/fp_mant_nr_divider.sv
// Iterative non-restoring 24-bit significand divider: one quotient bit per
// clock, then normalization into quotient, GRS and an exponent adjustment.
module fp_mant_nr_divider
    import fp_div_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MANT_W-1:0] mant_a,
    input  logic [MANT_W-1:0] mant_b,
    output logic              busy,
    output logic              done,
    output logic [MANT_W-1:0] quotient,
    output logic              guard,
    output logic              round_b,
    output logic              sticky,
    output logic [7:0]        exp_extra,
    output logic              div_by_zero
);

    // Handshake: start is accepted on a rising edge only while busy=0; done
    // is a single-cycle pulse and results stay valid until the next accept.
    divState_t         state;
    logic [MANT_W-1:0] bReg;
    logic [REM_W-1:0]  remReg;
    logic [QBITS-1:0]  qReg;
    logic [CNT_W-1:0]  cnt;

    logic [REM_W-1:0]  initRem;
    logic [REM_W-1:0]  stepRem;
    logic              stepQ;
    logic              isFix;
    logic              remNz;

    logic [MANT_W-1:0] nQuot;
    logic              nGuard;
    logic              nRound;
    logic              nSticky;
    logic [7:0]        nExp;

    assign initRem = {{(REM_W-MANT_W){1'b0}}, mant_a} - {{(REM_W-MANT_W){1'b0}}, mant_b};
    assign isFix   = (state == FIX);
    assign busy    = (state != IDLE);

    nr_div_step u_step (
        .remIn   (remReg),
        .divisor (bReg),
        .corr    (isFix),
        .remOut  (stepRem),
        .qBit    (stepQ)
    );

    assign remNz = |stepRem;

    // A leading zero quotient bit means the result is in [0.5,1): shift left one.
    always_comb begin
        nQuot   = qReg[QBITS-1 -: MANT_W];
        nGuard  = qReg[2];
        nRound  = qReg[1];
        nSticky = qReg[0] | remNz;
        nExp    = EXP_ADJ_NONE;
        if (!qReg[QBITS-1]) begin
            nQuot   = qReg[QBITS-2 -: MANT_W];
            nGuard  = qReg[1];
            nRound  = qReg[0];
            nSticky = remNz;
            nExp    = EXP_ADJ_M1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bReg        <= '0;
            remReg      <= '0;
            qReg        <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            guard       <= 1'b0;
            round_b     <= 1'b0;
            sticky      <= 1'b0;
            exp_extra   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bReg        <= mant_b;
                        div_by_zero <= (mant_b == '0);
                        if (mant_b == '0) begin
                            quotient  <= '0;
                            guard     <= 1'b0;
                            round_b   <= 1'b0;
                            sticky    <= 1'b0;
                            exp_extra <= EXP_ADJ_NONE;
                            state     <= DONE;
                        end else begin
                            remReg <= initRem;
                            qReg   <= {~initRem[REM_W-1], {(QBITS-1){1'b0}}};
                            cnt    <= CNT_W'(QBITS - 2);
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    remReg    <= stepRem;
                    qReg[cnt] <= stepQ;
                    cnt       <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= nQuot;
                    guard     <= nGuard;
                    round_b   <= nRound;
                    sticky    <= nSticky;
                    exp_extra <= nExp;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mant_nr_divider.sv
// Directed, table-driven bench for the significand divider.
module tb_fp_mant_nr_divider;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] q;
        logic        g;
        logic        r;
        logic        s;
        logic [7:0]  e;
        logic        dz;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] mant_a;
    logic [23:0] mant_b;
    logic        busy;
    logic        done;
    logic [23:0] quotient;
    logic        guard;
    logic        round_b;
    logic        sticky;
    logic [7:0]  exp_extra;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [35:0] exp_q[$];
    vec_t vecs[8];

    fp_mant_nr_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mant_a      (mant_a),
        .mant_b      (mant_b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .guard       (guard),
        .round_b     (round_b),
        .sticky      (sticky),
        .exp_extra   (exp_extra),
        .div_by_zero (div_by_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [35:0] pack_exp(input vec_t v);
        return {v.q, v.g, v.r, v.s, v.e, v.dz};
    endfunction

    function automatic logic [35:0] pack_act();
        return {quotient, guard, round_b, sticky, exp_extra, div_by_zero};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // driver: one start pulse at a negedge, accepted on the next rising edge
    task automatic issue(input logic [23:0] a, input logic [23:0] b);
        @(negedge clk);
        mant_a = a;
        mant_b = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mant_a = 24'($urandom_range(0, 32'hFFFFFF));
        mant_b = 24'($urandom_range(0, 32'hFFFFFF));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (done !== 1'b1 && lat < 60);
    endtask

    // scoreboard: compare current outputs against the oldest expectation
    task automatic score(input string name);
        logic [35:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, 64'(pack_act()), 64'(e));
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        check({name, "_idle_busy"}, 64'(busy), 64'd0);
        issue(v.a, v.b);
        exp_q.push_back(pack_exp(v));
        wait_done(lat);
        check({name, "_latency"}, 64'(lat), v.dz ? 64'd1 : 64'd28);
        score({name, "_result"});
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int base;
        vecs[0] = '{24'h800000, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{24'h800000, 24'hC00000, 24'hAAAAAA, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0};
        vecs[2] = '{24'hFFFFFF, 24'h800000, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{24'hC00000, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{24'h000000, 24'h800000, 24'h000000, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{24'h800000, 24'hFFFFFF, 24'h800000, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0};
        vecs[6] = '{24'hC00000, 24'hA00000, 24'h999999, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[7] = '{24'h800000, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};

        rst_n  = 1'b0;
        start  = 1'b0;
        mant_a = '0;
        mant_b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy_done", 64'({busy, done}), 64'd0);
        check("reset_results", 64'(pack_act()), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        run_vec(vecs[1], "after_dz");

        // start at E5 and in the DONE-state cycle must both be ignored
        issue(24'h800000, 24'hC00000);
        exp_q.push_back(pack_exp(vecs[1]));
        base = done_cnt;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 4) begin
                mant_a = 24'hFFFFFF;
                mant_b = 24'h800000;
                start  = 1'b1;
            end
            if (e == 5) start = 1'b0;
            if (e == 27) begin
                check("busy_in_done_state", 64'(busy), 64'd1);
                mant_b = 24'h000000;
                start  = 1'b1;
            end
            if (e == 28) begin
                start = 1'b0;
                check("ignored_start_done_e28", 64'(done), 64'd1);
                score("ignored_start_result");
            end
        end
        check("ignored_start_done_count", 64'(done_cnt - base), 64'd1);
        check("ignored_start_idle", 64'({busy, div_by_zero}), 64'd0);
        run_vec(vecs[2], "later_start");

        // reset in the middle of an operation
        issue(24'h800000, 24'hC00000);
        repeat (13) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy_done", 64'({busy, done}), 64'd0);
        check("midreset_results", 64'(pack_act()), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = done_cnt;
        repeat (35) @(posedge clk);
        #1;
        check("midreset_no_stray_done", 64'(done_cnt - base), 64'd0);
        check("midreset_idle", 64'(busy), 64'd0);
        run_vec(vecs[0], "after_reset");

        if (exp_q.size() != 0) begin
            check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
